calc_entry: RTL

Keypad entry sequencer that drives the operand and opcode inputs of the `calculator` block. It takes one-cycle key events from the keypad scanner, builds two decimal operands digit by digit, and latches the selected operation. On "equals" it presents the opcode so `calculator` produces `answer`/`signal`. All outputs are registered, so `calculator` only sees stable values.

---
 rtl/calc_entry.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/calc_entry.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry
// Purpose  : Keypad entry sequencer for the calculator block. It accepts
//            one-cycle key events, builds two decimal operands digit by
//            digit, latches the operation, and presents the opcode on
//            "equals". Every output is registered.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            key_valid - one-cycle key strobe
//            key_code  - 0-9 digit, A add, B sub, C mul, D clear, E equals
//            In1/In2   - operands to calculator (7 bits)
//            keyboard  - opcode to calculator (15 = no operation)
//            res_valid - high while the result state is active
//            err       - sticky entry error
//            state     - 0 OP1, 1 OP2, 2 RES, 3 CLR
// Revision : 1.0 - initial release
// ============================================================================
module calc_entry #(
  parameter int MAX_VAL = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] In1,
  output logic [6:0] In2,
  output logic [3:0] keyboard,
  output logic       res_valid,
  output logic       err,
  output logic [1:0] state
);

  localparam logic [1:0]  S_OP1 = 2'd0;
  localparam logic [1:0]  S_OP2 = 2'd1;
  localparam logic [1:0]  S_RES = 2'd2;
  localparam logic [1:0]  S_CLR = 2'd3;

  localparam logic [3:0]  c_KEY_ADD = 4'd10;
  localparam logic [3:0]  c_KEY_CLR = 4'd13;
  localparam logic [3:0]  c_KEY_EQ  = 4'd14;
  localparam logic [3:0]  c_KB_NOP  = 4'd15;
  localparam logic [10:0] c_MAX_VAL = 11'(MAX_VAL);

  logic [6:0]  r_in1;
  logic [6:0]  r_in2;
  logic [3:0]  r_kb;
  logic        r_res_valid;
  logic        r_err;
  logic [1:0]  r_state;
  logic [3:0]  r_op;

  logic        w_is_digit;
  logic        w_is_op;
  logic        w_clear;
  logic [6:0]  w_cur;
  logic [10:0] w_new;
  logic        w_accept;

  assign w_is_digit = key_code <= 4'd9;
  assign w_is_op    = (key_code >= 4'd10) && (key_code <= 4'd12);
  // Clear takes priority in every state except CLR itself, where keys drop.
  assign w_clear    = key_valid && (key_code == c_KEY_CLR) && (r_state != S_CLR);

  // Only one operand is ever being built, so a single accumulator path
  // serves both; the 11-bit width holds the worst case 127*10+9.
  assign w_cur    = (r_state == S_OP2) ? r_in2 : r_in1;
  assign w_new    = ({4'd0, w_cur} * 11'd10) + {7'd0, key_code};
  assign w_accept = w_new <= c_MAX_VAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in1       <= 7'd0;
      r_in2       <= 7'd0;
      r_kb        <= c_KB_NOP;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_state     <= S_OP1;
      r_op        <= c_KEY_ADD;
    end else if (w_clear) begin
      // One cycle of opcode 13 lets calculator zero its result.
      r_in1       <= 7'd0;
      r_in2       <= 7'd0;
      r_kb        <= c_KEY_CLR;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_state     <= S_CLR;
    end else begin
      case (r_state)
        S_OP1: begin
          if (key_valid) begin
            if (w_is_digit) begin
              if (w_accept) r_in1 <= w_new[6:0];
              else          r_err <= 1'b1;
            end else if (w_is_op) begin
              r_op    <= key_code;
              r_in2   <= 7'd0;
              r_state <= S_OP2;
            end
          end
        end
        S_OP2: begin
          if (key_valid) begin
            if (w_is_digit) begin
              if (w_accept) r_in2 <= w_new[6:0];
              else          r_err <= 1'b1;
            end else if (w_is_op) begin
              r_op <= key_code;
            end else if (key_code == c_KEY_EQ) begin
              r_kb        <= r_op;
              r_res_valid <= 1'b1;
              r_state     <= S_RES;
            end
          end
        end
        S_RES: begin
          if (key_valid) begin
            if (w_is_digit) begin
              // A digit starts a fresh calculation; a single digit always
              // fits since MAX_VAL is at least 9.
              r_in1       <= {3'd0, key_code};
              r_in2       <= 7'd0;
              r_kb        <= c_KB_NOP;
              r_res_valid <= 1'b0;
              r_state     <= S_OP1;
            end else if (w_is_op) begin
              // Chain on the previous operand 1.
              r_op        <= key_code;
              r_in2       <= 7'd0;
              r_kb        <= c_KB_NOP;
              r_res_valid <= 1'b0;
              r_state     <= S_OP2;
            end
          end
        end
        default: begin
          r_kb    <= c_KB_NOP;
          r_state <= S_OP1;
        end
      endcase
    end
  end

  assign In1       = r_in1;
  assign In2       = r_in2;
  assign keyboard  = r_kb;
  assign res_valid = r_res_valid;
  assign err       = r_err;
  assign state     = r_state;

endmodule
`default_nettype wire
